// File: rtl/burst_mem_pkg.sv
// rtl/burst_mem_pkg.sv - shared FSM state, burst mode constants and address stepping for burst_mem
package burst_mem_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_INCR = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    // Beats-minus-one values that form a power-of-two wrap block of 2..16 words.
    function automatic logic is_wrap_len(input logic [31:0] len);
        return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
    endfunction

    // For WRAP the low bits covered by len roll over inside the aligned block; the caller
    // truncates to the address width, which gives the modulo-depth roll for INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [31:0] len,
                                              input logic        mode);
        if (mode == MODE_WRAP) begin
            return (addr & ~len) | ((addr + 32'd1) & len);
        end
        return addr + 32'd1;
    endfunction

endpackage

// File: rtl/burst_mem_array.sv
// rtl/burst_mem_array.sv - word storage with byte-strobed write and registered, enabled read
module burst_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE-1];

    // Contents survive reset; only new writes are blocked while it is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // Nonblocking update means a same-edge write is not visible to this read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/burst_mem.sv
// rtl/burst_mem.sv - burst-read memory with strobed single-beat writes; BURST_MEM_WRAP_EN enables WRAP bursts
module burst_mem
    import burst_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_SIZE   = 1024,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [ADDR_WIDTH-1:0]   rd_req_addr,
    input  logic [LEN_WIDTH-1:0]    rd_req_len,
    input  logic                    rd_req_wrap,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    busy
);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] step_addr;
    logic [LEN_WIDTH-1:0]  remain;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  mode_q;
    logic                  req_fire;
    logic                  beat_fire;
    logic                  issue_next;
    logic                  arr_rd_en;
    logic [ADDR_WIDTH-1:0] arr_rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rd_req_ready = 1'b0;
        busy         = 1'b0;
        req_fire     = 1'b0;
        issue_next   = 1'b0;
        beat_fire    = rd_valid && rd_ready;
        case (state)
            ST_IDLE: begin
                rd_req_ready = !rd_valid;
                req_fire     = rd_req_valid && !rd_valid;
                if (req_fire) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (beat_fire) begin
                    if (remain != '0) begin
                        issue_next = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign step_addr   = ADDR_WIDTH'(next_addr(32'(cur_addr), 32'(len_q), mode_q));
    assign arr_rd_en   = req_fire || issue_next;
    assign arr_rd_addr = req_fire ? rd_req_addr : step_addr;

`ifndef BURST_MEM_WRAP_EN
    logic unused_wrap;
    assign unused_wrap = rd_req_wrap;
`endif

    // cur_addr tracks the word currently presented (or being fetched) on rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr <= '0;
            remain   <= '0;
            len_q    <= '0;
            mode_q   <= MODE_INCR;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else if (req_fire) begin
            cur_addr <= rd_req_addr;
            remain   <= rd_req_len;
            len_q    <= rd_req_len;
`ifdef BURST_MEM_WRAP_EN
            mode_q   <= (rd_req_wrap && is_wrap_len(32'(rd_req_len))) ? MODE_WRAP : MODE_INCR;
`else
            mode_q   <= MODE_INCR;
`endif
            rd_valid <= 1'b1;
            rd_last  <= (rd_req_len == '0);
        end else if (issue_next) begin
            cur_addr <= step_addr;
            remain   <= remain - LEN_WIDTH'(1);
            rd_last  <= (remain == LEN_WIDTH'(1));
        end else if (beat_fire) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end
    end

    burst_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_en   (arr_rd_en),
        .rd_addr (arr_rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_burst_mem.sv
// tb/tb_burst_mem.sv - self-checking bench for burst_mem against a behavioural memory model
module tb_burst_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        rd_req_valid = 1'b0;
    logic        rd_req_ready;
    logic [9:0]  rd_req_addr = '0;
    logic [7:0]  rd_req_len = '0;
    logic        rd_req_wrap = 1'b0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        busy;

    bit [31:0]   model [0:1023];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] first_data;

    always #5 clk = ~clk;

    burst_mem #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10),
        .MEM_SIZE   (1024),
        .LEN_WIDTH  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_req_len   (rd_req_len),
        .rd_req_wrap  (rd_req_wrap),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .busy         (busy)
    );

    function automatic int exp_addr(input int start, input int len, input int wrap, input int k);
        int n;
        int base;
        n = len + 1;
        base = 0;
`ifdef BURST_MEM_WRAP_EN
        if (wrap != 0 && (n == 2 || n == 4 || n == 8 || n == 16)) begin
            base = start - (start % n);
            return base + ((start - base + k) % n);
        end
`endif
        return (start + k + base * wrap * 0) % 1024;
    endfunction

    task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] s);
        wr_addr = 10'(a);
        wr_data = d;
        wr_strb = s;
        wr_en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
        end
    endtask

    // rmode: 0 ready always high, 1 ready pattern 1,0,0 repeating, 2 random.
    // noise keeps a bogus request asserted during the burst, which must be ignored.
    task automatic run_burst(input int start, input int len, input int wrap,
                             input int rmode, input int noise, input string name);
        int          k;
        int          cyc;
        int          ea;
        logic        rdy;
        logic        stall_prev;
        logic [31:0] prev_data;
        logic        prev_last;
        rd_req_addr  = 10'(start);
        rd_req_len   = 8'(len);
        rd_req_wrap  = wrap[0];
        rd_req_valid = 1'b1;
        rd_ready     = 1'b0;
        cyc = 0;
        while (rd_req_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (rd_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s req_timeout rd_req_ready=%b required=1", name, rd_req_ready);
            rd_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (noise != 0) begin
            rd_req_addr = 10'($urandom);
            rd_req_len  = 8'($urandom);
        end else begin
            rd_req_valid = 1'b0;
        end
        checks++;
        if (rd_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s latency rd_valid=%b busy=%b required 1 1", name, rd_valid, busy);
        end
        k = 0;
        cyc = 0;
        stall_prev = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        while (k <= len && cyc < 400) begin
            if (stall_prev) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== prev_data || rd_last !== prev_last) begin
                    failures++;
                    $display("FAIL %s stall_hold valid=%b data=%h last=%b required 1 %h %b",
                             name, rd_valid, rd_data, rd_last, prev_data, prev_last);
                end
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            rd_ready = rdy;
            if (noise != 0) begin
                checks++;
                if (rd_req_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s ready_in_burst rd_req_ready=%b required=0", name, rd_req_ready);
                end
            end
            if (rd_valid === 1'b1) begin
                if (rdy) begin
                    ea = exp_addr(start, len, wrap, k);
                    if (k == 0) first_data = rd_data;
                    checks++;
                    if (rd_data !== model[ea] || rd_last !== (k == len)) begin
                        failures++;
                        $display("FAIL %s beat%0d addr=%h data=%h last=%b required %h %b",
                                 name, k, ea, rd_data, rd_last, model[ea], (k == len));
                    end
                    k++;
                    if (k > len) rd_req_valid = 1'b0;
                end
                stall_prev = !rdy;
                prev_data  = rd_data;
                prev_last  = rd_last;
            end else begin
                checks++;
                failures++;
                $display("FAIL %s bubble beat%0d rd_valid=%b required=1", name, k, rd_valid);
                stall_prev = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        rd_ready     = 1'b0;
        rd_req_valid = 1'b0;
        if (k <= len) begin
            checks++;
            failures++;
            $display("FAIL %s beat_timeout beats=%0d required=%0d", name, k, len + 1);
        end
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s end_state valid=%b busy=%b req_ready=%b required 0 0 1",
                     name, rd_valid, busy, rd_req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== 32'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs valid=%b last=%b data=%h busy=%b required 0 0 0 0",
                     rd_valid, rd_last, rd_data, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release req_ready=%b busy=%b required 1 0", rd_req_ready, busy);
        end
    endtask

    task automatic test_fill();
        for (int a = 0; a < 1024; a++) do_write(a, $urandom, 4'hF);
    endtask

    task automatic test_strobe_write();
        do_write(16, 32'hA5A5A5A5, 4'hF);
        do_write(16, 32'h00001100, 4'h2);
        run_burst(16, 0, 0, 0, 0, "strobe");
        checks++;
        if (first_data !== 32'hA5A511A5) begin
            failures++;
            $display("FAIL strobe_value data=%h required=a5a511a5", first_data);
        end
    endtask

    task automatic test_incr_boundary();
        run_burst(32'h3FE, 3, 0, 0, 0, "incr_rollover");
    endtask

    task automatic test_backpressure();
        run_burst(32'h055, 2, 0, 1, 1, "backpressure");
    endtask

    task automatic test_wrap_mode();
        run_burst(32'h006, 3, 1, 0, 0, "wrap_len3");
        run_burst(32'h00B, 7, 1, 2, 0, "wrap_len7");
        run_burst(32'h012, 2, 1, 0, 0, "wrap_len2_incr");
    endtask

    task automatic test_same_edge();
        logic [31:0] old;
        do_write(32, 32'hDEAD0000, 4'hF);
        old = model[32];
        rd_req_addr  = 10'h020;
        rd_req_len   = 8'd0;
        rd_req_wrap  = 1'b0;
        rd_req_valid = 1'b1;
        rd_ready     = 1'b0;
        wr_addr      = 10'h020;
        wr_data      = 32'h1;
        wr_strb      = 4'hF;
        wr_en        = 1'b1;
        checks++;
        if (rd_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL same_edge_ready rd_req_ready=%b required=1", rd_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rd_req_valid = 1'b0;
        wr_en        = 1'b0;
        model[32]    = 32'h1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== old || rd_last !== 1'b1) begin
            failures++;
            $display("FAIL same_edge_old valid=%b data=%h last=%b required 1 %h 1",
                     rd_valid, rd_data, rd_last, old);
        end
        rd_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_ready = 1'b0;
        run_burst(32, 0, 0, 0, 0, "same_edge_new");
        checks++;
        if (first_data !== 32'h1) begin
            failures++;
            $display("FAIL same_edge_new_value data=%h required=00000001", first_data);
        end
    endtask

    task automatic test_reset_midburst();
        rd_req_addr  = 10'h100;
        rd_req_len   = 8'd7;
        rd_req_wrap  = 1'b0;
        rd_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd_ready = 1'b1;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== model[256 + k]) begin
                failures++;
                $display("FAIL abort_beat%0d valid=%b data=%h required 1 %h",
                         k, rd_valid, rd_data, model[256 + k]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        rd_ready = 1'b0;
        #2;
        rst_n   = 1'b0;
        wr_addr = 10'h101;
        wr_data = ~model[257];
        wr_strb = 4'hF;
        wr_en   = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_last !== 1'b0 || rd_data !== 32'h0) begin
            failures++;
            $display("FAIL abort_immediate valid=%b busy=%b last=%b data=%h required 0 0 0 0",
                     rd_valid, busy, rd_last, rd_data);
        end
        rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold valid=%b busy=%b required 0 0", rd_valid, busy);
        end
        wr_en    = 1'b0;
        rd_ready = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_req_ready !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_recover req_ready=%b valid=%b required 1 0", rd_req_ready, rd_valid);
        end
        run_burst(32'h100, 7, 0, 0, 0, "after_abort");
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            for (int w = 0; w < 3; w++) begin
                do_write($urandom_range(0, 1023), $urandom, 4'($urandom));
            end
            run_burst($urandom_range(0, 1023), $urandom_range(0, 15), $urandom_range(0, 1),
                      2, $urandom_range(0, 1), "random");
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_strobe_write();
        test_incr_boundary();
        test_backpressure();
        test_wrap_mode();
        test_same_edge();
        test_reset_midburst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/burst_mem.md
BURST_MEM -- requirements
Module: burst_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: word address width.
REQ-003 SHALL have parameter MEM_SIZE, default 1024: depth in words; equals 2**ADDR_WIDTH.
REQ-004 SHALL have parameter LEN_WIDTH, default 8: burst length field width.
REQ-005 SHALL have one clock; reset is asynchronous and active-low. Ports: clk, rst_n.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 wr_en  input  1  write strobe, single beat.
REQ-009 wr_addr  input  ADDR_WIDTH  write word address.
REQ-010 wr_data  input  DATA_WIDTH  write data.
REQ-011 wr_strb  input  DATA_WIDTH/8  byte enables; bit i covers byte i.
REQ-012 rd_req_valid  input  1  burst request valid.
REQ-013 rd_req_ready  output  1  burst request accepted when high with valid.
REQ-014 rd_req_addr  input  ADDR_WIDTH  burst start word address.
REQ-015 rd_req_len  input  LEN_WIDTH  beats minus one.
REQ-016 rd_req_wrap  input  1  1 = WRAP burst, 0 = INCR.
REQ-017 rd_valid  output  1  read beat valid.
REQ-018 rd_ready  input  1  consumer accepts beat.
REQ-019 rd_data  output  DATA_WIDTH  read beat data.
REQ-020 rd_last  output  1  final beat of burst, qualified by rd_valid.
REQ-021 busy  output  1  burst in progress.

Function
REQ-022 Write: on wr_en at a clock edge, byte i of mem[wr_addr] SHALL take wr_data byte i where wr_strb[i]=1; other bytes unchanged; writes always accepted, independent of read state.
REQ-023 FSM states IDLE, RUN. rd_req_ready = 1 only in IDLE with rd_valid = 0.
REQ-024 IDLE -> RUN on rd_req_valid & rd_req_ready; addr, len, mode captured; first word read issued at that same edge.
REQ-025 Latency: request handshake at edge N -> rd_valid=1 with mem[start] during cycle after edge N.
REQ-026 rd_data/rd_valid/rd_last SHALL hold stable while rd_valid & !rd_ready.
REQ-027 Next word read issued when rd_valid & rd_ready and beats remain; with rd_ready held high one beat per cycle, no bubbles.
REQ-028 Exactly rd_req_len+1 beats; rd_last high on the final one; RUN -> IDLE on its handshake; busy high from request handshake through final beat handshake.
REQ-029 INCR: address +1 per beat modulo MEM_SIZE (MEM_SIZE-1 -> 0).
REQ-030 Same-edge write and read of one address: rd_data SHALL return the pre-write contents.
REQ-031 rd_req_valid while not ready SHALL be ignored; no request queueing.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, rd_valid=0, rd_last=0, rd_data=0, busy=0, aborting any burst; no further beats.
REQ-033 Memory contents SHALL NOT be reset; writes are blocked while rst_n low.
REQ-034 rd_req_ready SHALL be 1 from the first edge after rst_n rises.

Configuration
REQ-035 Macro BURST_MEM_WRAP_EN defined: rd_req_wrap=1 with len+1 in {2,4,8,16} SHALL wrap address within the (len+1)-word aligned block containing start; other lengths treated as INCR.
REQ-036 BURST_MEM_WRAP_EN undefined: rd_req_wrap SHALL be ignored; all bursts INCR; port still present.

Structure
REQ-037 Package burst_mem_pkg SHALL hold FSM state typedef, burst mode constants, next-address function.
REQ-038 Sub-module burst_mem_array SHALL hold storage: strobed write, registered read with enable.

Verification
REQ-039 Write 0xA5A5A5A5 @0x10 strb 0xF, then 0x00001100 strb 0x2 -> INCR len 0 @0x10 returns 0xA5A511A5, rd_last=1.
REQ-040 INCR len 3 @0x3FE, rd_ready high -> beats @0x3FE,0x3FF,0x000,0x001 on consecutive cycles, rd_last on 4th.
REQ-041 INCR len 2 with rd_ready toggling 1,0,0,1,... -> data/last stable while stalled, exactly 3 handshakes.
REQ-042 WRAP_EN: WRAP len 3 @0x06 -> addresses 0x06,0x07,0x04,0x05; without macro -> 0x06..0x09.
REQ-043 Write 0x1 @0x20 same edge as its read issue -> old value returned; next burst returns 0x1.
REQ-044 rst_n low mid-burst after 2 of 8 beats -> rd_valid/busy drop immediately; new request after reset served normally.
